// File: rtl/seven_seg_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_if
// Display-side bundle of the 7-segment scanner: the value/decimal-point/blank
// requests coming from the ROM reader top, and the multiplexed common-anode
// display drive going out to the board.
//   master : drives value_in, dp_in, blank_in; observes the display outputs
//   slave  : the scanner itself
// Signals:
//   value_in    [15:0] value to show, nibble k -> digit k (digit 0 rightmost)
//   dp_in       [3:0]  decimal point request per digit, active-high
//   blank_in           1 = all digits off, scanning continues
//   segments_n  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp_n               decimal point, active-low
//   digit_sel_n [3:0]  digit enables, active-low, bit k = digit k
//   frame_start        one-clock pulse when a new snapshot is taken
// ---------------------------------------------------------------------------
interface seven_seg_scanner_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank_in;
  logic [6:0]  segments_n;
  logic        dp_n;
  logic [3:0]  digit_sel_n;
  logic        frame_start;

  modport master (
    output value_in, dp_in, blank_in,
    input  segments_n, dp_n, digit_sel_n, frame_start
  );

  modport slave (
    input  value_in, dp_in, blank_in,
    output segments_n, dp_n, digit_sel_n, frame_start
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Multiplexes a 16-bit value as four hex digits on a common-anode 4-digit
// 7-segment display. A snapshot of value/dp is taken once per scan frame (on
// the digit 3 -> 0 wrap) so a frame never mixes old and new values, and each
// digit slot begins with BLANK_CYCLES clocks of all-digits-off dead time so
// segment changes are never visible on a lit digit.
// Parameters:
//   SCAN_DIV      clocks per digit slot (>= 2)
//   BLANK_CYCLES  dead-time clocks at the start of each slot (< SCAN_DIV)
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      seven_seg_scanner_if.slave (value/dp/blank in, display out)
// Optional build macro:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN - leading zero digits (never digit 0)
//   show no segments; the digit is still scanned so its decimal point works.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  seven_seg_scanner_if.slave  bus
);

  localparam int             PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  LAST_CNT  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]  BLANK_CNT = PW'(BLANK_CYCLES);

  // Active-low g..a patterns for hex digits.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic          started_q, started_d;   // first tick seen since reset
  logic [15:0]   snap_value_q, snap_value_d;
  logic [3:0]    snap_dp_q, snap_dp_d;

  // Registered outputs
  logic [3:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          tick;
  logic          wrap;
  logic          in_blank;
  logic          enabled;
  logic [3:0]    nib;
  logic [15:0]   upper;                  // current nibble and all above it

  assign tick = (presc_q == LAST_CNT);
  assign wrap = tick && (idx_q == 2'd3);

  // Next scan state
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    started_d    = started_q | tick;
    snap_value_d = snap_value_q;
    snap_dp_d    = snap_dp_q;
    if (wrap) begin
      snap_value_d = bus.value_in;
      snap_dp_d    = bus.dp_in;
    end
  end

  // Next output values are derived from the next scan state so that the
  // registered outputs line up with the prescaler value they belong to.
  // Segments follow only idx/snapshot, which change solely on a tick, i.e.
  // at the start of a slot while every digit is still off.
  always_comb begin
    in_blank = (presc_d < BLANK_CNT);
    enabled  = started_d && !in_blank && !bus.blank_in;
    upper    = snap_value_d >> {idx_d, 2'b00};
    nib      = upper[3:0];
    sel_d    = enabled ? ~(4'b0001 << idx_d) : 4'hF;
    seg_d    = started_d ? hex7(nib) : 7'h7F;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (idx_d != 2'd0 && upper == 16'h0000) begin
      seg_d = 7'h7F;
    end
`else
`endif
    dp_d     = ~(enabled & snap_dp_d[idx_d]);
    fs_d     = wrap;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd3;
      started_q    <= 1'b0;
      snap_value_q <= 16'h0000;
      snap_dp_q    <= 4'h0;
      sel_q        <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      started_q    <= started_d;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign bus.digit_sel_n = sel_q;
  assign bus.segments_n  = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.frame_start = fs_q;

endmodule
